// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard bundle: source/destination info in, issue/stall/forward selects out.
// The master side is the ID stage (or its model); the slave side is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int NUM_READ = 2,
    parameter int DEPTH    = 3,
    parameter int ADDR_W   = 5,
    parameter int SEL_W    = $clog2(DEPTH + 1)
);
    logic                         id_valid;
    logic [NUM_READ-1:0]          id_re;
    logic [NUM_READ*ADDR_W-1:0]   id_raddr;
    logic                         id_we;
    logic [ADDR_W-1:0]            id_waddr;
    logic                         id_is_load;
    logic                         ex_allow;
    logic                         flush;
    logic                         id_allow;
    logic                         stall;
    logic [NUM_READ*SEL_W-1:0]    fwd_sel;

    modport master (
        output id_valid, id_re, id_raddr, id_we, id_waddr, id_is_load, ex_allow, flush,
        input  id_allow, stall, fwd_sel
    );

    modport slave (
        input  id_valid, id_re, id_raddr, id_we, id_waddr, id_is_load, ex_allow, flush,
        output id_allow, stall, fwd_sel
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard beside ID: shadow destination pipeline, youngest-match forwarding, load-use stall.
// Optional HAZARD_SCOREBOARD_PERF_EN adds a saturating stall_cnt output counting stalled advance cycles.
module hazard_scoreboard #(
    parameter int NUM_READ = 2,
    parameter int DEPTH    = 3,
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    hazard_scoreboard_if.slave   sb
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    // Entry k = k stages past ID; entry 1 is EX (youngest)
    logic [DEPTH:1]    ent_v_r;
    logic [DEPTH:1]    ent_ld_r;
    logic [ADDR_W-1:0] ent_addr_r [1:DEPTH];

    logic [NUM_READ*SEL_W-1:0] fwd_sel_s;
    logic [NUM_READ-1:0]       hazard_s;
    logic                      stall_s;
    logic                      id_allow_s;
    logic                      issue_s;
    logic                      ent1_v_s;

    function automatic logic entry_hit(
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic              v,
        input logic [ADDR_W-1:0] eaddr
    );
        return re && (raddr != {ADDR_W{1'b0}}) && v && (eaddr == raddr);
    endfunction

    // Per-port compare: scan oldest to youngest so the youngest hit overrides
    always_comb begin
        fwd_sel_s = {(NUM_READ*SEL_W){1'b0}};
        hazard_s  = {NUM_READ{1'b0}};
        for (int i = 0; i < NUM_READ; i++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (entry_hit(sb.id_re[i], sb.id_raddr[i*ADDR_W +: ADDR_W],
                              ent_v_r[k], ent_addr_r[k])) begin
                    fwd_sel_s[i*SEL_W +: SEL_W] = SEL_W'(k);
                    hazard_s[i]                 = ent_ld_r[k] && (k < LOAD_LAT);
                end else begin
                    fwd_sel_s[i*SEL_W +: SEL_W] = fwd_sel_s[i*SEL_W +: SEL_W];
                    hazard_s[i]                 = hazard_s[i];
                end
            end
        end
    end

    // Issue decision and the valid bit that would enter entry 1
    always_comb begin
        stall_s    = sb.id_valid & (|hazard_s);
        id_allow_s = sb.ex_allow & ~stall_s;
        issue_s    = sb.id_valid & id_allow_s;
        ent1_v_s   = issue_s & sb.id_we & (sb.id_waddr != {ADDR_W{1'b0}});
    end

    assign sb.stall    = stall_s;
    assign sb.id_allow = id_allow_s;
    assign sb.fwd_sel  = fwd_sel_s;

    // Shadow pipeline: flush wins over advance; a non-issuing advance inserts a bubble
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent_v_r  <= {DEPTH{1'b0}};
            ent_ld_r <= {DEPTH{1'b0}};
            for (int k = 1; k <= DEPTH; k++) begin
                ent_addr_r[k] <= {ADDR_W{1'b0}};
            end
        end else if (sb.flush) begin
            ent_v_r <= {DEPTH{1'b0}};
        end else if (sb.ex_allow) begin
            for (int k = DEPTH; k >= 2; k--) begin
                ent_v_r[k]    <= ent_v_r[k-1];
                ent_ld_r[k]   <= ent_ld_r[k-1];
                ent_addr_r[k] <= ent_addr_r[k-1];
            end
            ent_v_r[1]    <= ent1_v_s;
            ent_ld_r[1]   <= issue_s & sb.id_is_load;
            ent_addr_r[1] <= issue_s ? sb.id_waddr : {ADDR_W{1'b0}};
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles the backend advanced while ID was held by a load-use stall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && sb.ex_allow && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard (default parameters) plus multi-cycle corner sequences.
module tb_hazard_scoreboard;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    hazard_scoreboard_if #(.NUM_READ(2), .DEPTH(3), .ADDR_W(5)) sb_if ();

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt;
    hazard_scoreboard dut (.clk(clk), .resetn(resetn), .sb(sb_if.slave), .stall_cnt(stall_cnt));
`else
    hazard_scoreboard dut (.clk(clk), .resetn(resetn), .sb(sb_if.slave));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [1:0] re;
        logic [4:0] ra0;
        logic [4:0] ra1;
        logic       we;
        logic [4:0] wa;
        logic       ld;
        logic       ex;
        logic       fl;
        logic       e_stall;
        logic       e_allow;
        logic [1:0] e_sel0;
        logic [1:0] e_sel1;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic va, input logic [1:0] re, input logic [4:0] r0,
                                input logic [4:0] r1, input logic we, input logic [4:0] wa,
                                input logic ld, input logic ex, input logic fl, input logic es,
                                input logic ea, input logic [1:0] s0, input logic [1:0] s1);
        vec_t v;
        v.valid = va; v.re = re; v.ra0 = r0; v.ra1 = r1; v.we = we; v.wa = wa; v.ld = ld;
        v.ex = ex; v.fl = fl; v.e_stall = es; v.e_allow = ea; v.e_sel0 = s0; v.e_sel1 = s1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        sb_if.id_valid   = v.valid;
        sb_if.id_re      = v.re;
        sb_if.id_raddr   = {v.ra1, v.ra0};
        sb_if.id_we      = v.we;
        sb_if.id_waddr   = v.wa;
        sb_if.id_is_load = v.ld;
        sb_if.ex_allow   = v.ex;
        sb_if.flush      = v.fl;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        chk({tag, ".stall"},    32'(sb_if.stall),        32'(v.e_stall));
        chk({tag, ".id_allow"}, 32'(sb_if.id_allow),     32'(v.e_allow));
        chk({tag, ".fwd_sel0"}, 32'(sb_if.fwd_sel[1:0]), 32'(v.e_sel0));
        chk({tag, ".fwd_sel1"}, 32'(sb_if.fwd_sel[3:2]), 32'(v.e_sel1));
    endtask

    task automatic step(input string tag, input vec_t v);
        apply(v);
        #1;
        check_out(tag, v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;

        //           va    re     r0     r1     we    wa     ld    ex    fl    st    al    s0     s1
        vecs[0]  = mk(1'b1, 2'b11, 5'd4,  5'd5,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        vecs[1]  = mk(1'b1, 2'b11, 5'd4,  5'd5,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        vecs[2]  = mk(1'b1, 2'b00, 5'd0,  5'd0,  1'b1, 5'd6,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        vecs[3]  = mk(1'b1, 2'b11, 5'd6,  5'd1,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0);
        vecs[4]  = mk(1'b1, 2'b11, 5'd6,  5'd6,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2);
        vecs[5]  = mk(1'b1, 2'b01, 5'd6,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0);
        vecs[6]  = mk(1'b1, 2'b01, 5'd6,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        vecs[7]  = mk(1'b1, 2'b00, 5'd0,  5'd0,  1'b1, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        vecs[8]  = mk(1'b1, 2'b10, 5'd0,  5'd7,  1'b1, 5'd9,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1);
        vecs[9]  = mk(1'b1, 2'b10, 5'd0,  5'd7,  1'b1, 5'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2);
        vecs[10] = mk(1'b1, 2'b11, 5'd9,  5'd7,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3);
        vecs[11] = mk(1'b1, 2'b00, 5'd0,  5'd0,  1'b1, 5'd8,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        vecs[12] = mk(1'b1, 2'b01, 5'd8,  5'd0,  1'b1, 5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0);
        vecs[13] = mk(1'b1, 2'b01, 5'd8,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0);
        vecs[14] = mk(1'b1, 2'b01, 5'd8,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0);
        vecs[15] = mk(1'b1, 2'b11, 5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        vecs[16] = mk(1'b1, 2'b11, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        vecs[17] = mk(1'b1, 2'b00, 5'd0,  5'd0,  1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        vecs[18] = mk(1'b0, 2'b11, 5'd10, 5'd10, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1);
        vecs[19] = mk(1'b1, 2'b00, 5'd10, 5'd10, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        vecs[20] = mk(1'b1, 2'b11, 5'd10, 5'd11, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0);

        // Reset state while inputs present a live instruction
        resetn = 1'b0;
        apply(vecs[0]);
        #3;
        check_out("reset_ex1", vecs[0]);
        apply(vecs[1]);
        #1;
        check_out("reset_ex0", vecs[1]);
`ifdef HAZARD_SCOREBOARD_PERF_EN
        chk("reset.stall_cnt", stall_cnt, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end
`ifdef HAZARD_SCOREBOARD_PERF_EN
        chk("table.stall_cnt", stall_cnt, 32'd2);
`endif

        // Flush in the same cycle as a load-use stall
        step("flush_ld", mk(1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
        step("flush_hit", mk(1'b1, 2'b01, 5'd12, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd0));
        step("flush_after", mk(1'b1, 2'b01, 5'd12, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
`ifdef HAZARD_SCOREBOARD_PERF_EN
        chk("flush.stall_cnt", stall_cnt, 32'd3);
`endif

        // Backend hold: entries and forwarding select frozen while ex_allow=0
        step("hold_add", mk(1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
        step("hold_idle", mk(1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
        for (int c = 0; c < 3; c++) begin
            step($sformatf("hold%0d", c),
                 mk(1'b1, 2'b10, 5'd0, 5'd13, 1'b1, 5'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2));
        end
        step("hold_go", mk(1'b1, 2'b10, 5'd0, 5'd13, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2));
        step("hold_next", mk(1'b1, 2'b10, 5'd0, 5'd13, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3));

        // Asynchronous reset mid-stall
        step("arst_ld", mk(1'b1, 2'b00, 5'd0, 5'd0, 1'b1, 5'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
        v = mk(1'b1, 2'b01, 5'd15, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0);
        apply(v);
        #1;
        check_out("arst_pre", v);
        #1;
        resetn = 1'b0;
        #1;
        chk("arst.stall",    32'(sb_if.stall),    32'd0);
        chk("arst.fwd_sel",  32'(sb_if.fwd_sel),  32'd0);
        chk("arst.id_allow", 32'(sb_if.id_allow), 32'd1);
`ifdef HAZARD_SCOREBOARD_PERF_EN
        chk("arst.stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        step("arst_post", mk(1'b1, 2'b01, 5'd15, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register-hazard scoreboard for the in-order pipeline, sitting beside the ID stage. It keeps a shadow pipeline of destination registers for the DEPTH stages after ID and compares every ID source register against it. From that comparison it produces a per-port forwarding select and a load-use stall. It replaces the fixed three-stage, two-port address compare with youngest-match priority, load latency awareness, flush, and bubble insertion.

## Interface
Parameters:
- NUM_READ, 2, number of ID register read ports
- DEPTH, 3, tracked stages after ID (entry 1 = EX, youngest)
- ADDR_W, 5, register address width
- LOAD_LAT, 2, first entry index whose load result is forwardable; load matched at entry k < LOAD_LAT stalls
- SEL_W, $clog2(DEPTH+1), derived width of one forwarding select

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_re  in  NUM_READ  per-port read enable
- id_raddr  in  NUM_READ*ADDR_W  per-port source address, port i at [i*ADDR_W +: ADDR_W]
- id_we  in  1  ID instruction writes a register
- id_waddr  in  ADDR_W  ID destination address
- id_is_load  in  1  ID instruction is a load
- ex_allow  in  1  backend advances this cycle (lockstep)
- flush  in  1  kill all tracked entries
- id_allow  out  1  ID instruction issues this cycle
- stall  out  1  load-use hazard present
- fwd_sel  out  NUM_READ*SEL_W  per port: 0 = regfile, k = forward from entry k

## Operation
- Entry k (1..DEPTH) state: v, addr[ADDR_W], ld. Entry valid only if v=1.
- Stored v is (issue & id_we & id_waddr!=0). Register 0 is never tracked or matched.
- Port i match: id_re[i] & id_raddr_i!=0 & entry v & entry addr==id_raddr_i.
- The youngest (lowest k) match wins. fwd_sel_i = k, or 0 if there is no match.
- Port hazard when the winning entry has ld=1 and k < LOAD_LAT.
- stall = id_valid & OR of port hazards.
- When stall is high, fwd_sel still reports the winning k. The consumer ignores it.
- id_allow = ex_allow & ~stall. issue = id_valid & id_allow.
- On advance (ex_allow=1), entry k gets entry k-1 for k ≥ 2.
- On advance, entry 1 gets the ID fields if issue=1, otherwise a bubble (v=0).
- When ex_allow=0, all entries hold.
- When flush=1, all v bits clear at the next edge. flush beats advance, so nothing is loaded into entry 1 that cycle.
- The oldest entry (DEPTH) drops off on advance. The regfile is assumed written by then.

## Timing
- Reset: all entries v=0, addr=0, ld=0; stall=0, fwd_sel=0, id_allow=ex_allow.
- Reset is asynchronous, asserts immediately mid-operation, and releases synchronously to the design.
- The path from id_* / ex_allow to stall, fwd_sel and id_allow is combinational, with zero-cycle latency.
- Entry updates occur at the rising edge following the qualifying inputs.
- Load-use penalty: with LOAD_LAT=2, a consumer directly behind a load stalls 1 cycle. It then gets fwd_sel=2.
- Width rule: fwd_sel values range 0..DEPTH and always fit in SEL_W bits.
- Simultaneous events:
  - flush together with stall: entries clear, and the stall drops the following cycle.
  - Same address in multiple entries: the youngest wins even if an older entry is a load.
  - Both ports hitting the same entry each report it independently.

## Configuration
- Macro: HAZARD_SCOREBOARD_PERF_EN.
- Defined: adds output stall_cnt out 32, reset 0.
- stall_cnt increments on every cycle with stall=1 & ex_allow=1 and saturates at 32'hFFFF_FFFF.
- flush does not clear stall_cnt.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- After reset, with id_valid=1, id_re=2'b11 and addrs r4/r5 -> stall=0, fwd_sel all 0, id_allow=ex_allow.
- Issue add r6 (we, not load), then a consumer reading r6 on port 0 the next cycle -> fwd_sel0=1, stall=0.
- Consumer two cycles later -> fwd_sel0=2. Three cycles later -> 3. Four cycles later -> 0.
- Issue ld r7, then a consumer reading r7 the next cycle -> stall=1 and id_allow=0 for exactly 1 cycle.
  - A bubble enters entry 1 during the stall.
  - The consumer then issues with fwd_sel=2.
  - stall_cnt=1 when HAZARD_SCOREBOARD_PERF_EN is defined.
- Issue add r8, then ld r8 -> a consumer of r8 sees the load at entry 1 and stalls, ignoring the older add at entry 2.
- Consumers reading r0 never match, even after writes to r0.
- Load in entry 1 while the consumer stalls, flush=1 in the same cycle -> the next cycle has all entries empty, stall=0 and fwd_sel=0.
- ex_allow=0 for 3 cycles -> entries hold and fwd_sel stays constant.
- Assert resetn=0 mid-stream -> stall and fwd_sel go 0 without waiting for a clock edge.
